// File: rtl/oc_bank_arbiter.sv
// Operand-collector bank arbiter: four per-bank read-request FIFOs feeding the
// register-file read ports. Writebacks take priority, and each read returns a tag one cycle later.
module oc_bank_arbiter #(
  parameter int DEPTH   = 4,
  parameter int RADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Valid_RAU_OC,
  input  logic                 Src1_Read_RAU_OC,
  input  logic                 Src2_Read_RAU_OC,
  input  logic [2:0]           Src1_OCID_RAU_OC,
  input  logic [2:0]           Src2_OCID_RAU_OC,
  input  logic [1:0]           Src1_Phy_Bank_ID,
  input  logic [1:0]           Src2_Phy_Bank_ID,
  input  logic [RADDR_W-1:0]   Src1_Addr_RAU_OC,
  input  logic [RADDR_W-1:0]   Src2_Addr_RAU_OC,
  input  logic [3:0]           RF_WR,
  output logic                 Stall_OC_RAU,
  output logic [3:0]           RF_RD,
  output logic [4*RADDR_W-1:0] RF_RdAddr,
  output logic [3:0]           ocid_0,
  output logic [3:0]           ocid_1,
  output logic [3:0]           ocid_2,
  output logic [3:0]           ocid_3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 3 + RADDR_W;

  typedef logic [EW-1:0] entry_t;

  entry_t         mem    [4][DEPTH];
  logic [PW-1:0]  wptr   [4];
  logic [PW-1:0]  rptr   [4];
  logic [CW-1:0]  count  [4];
  logic [3:0]     ocid_r [4];

  logic [3:0] req1, req2, push1, push2, pop_en;
  logic       stall;
  logic       v_eff;
  entry_t     e1, e2;

  assign v_eff = Valid_RAU_OC & ~rst;
  assign e1    = {Src1_OCID_RAU_OC, Src1_Addr_RAU_OC};
  assign e2    = {Src2_OCID_RAU_OC, Src2_Addr_RAU_OC};

  always_comb begin
    req1      = '0;
    req2      = '0;
    pop_en    = '0;
    stall     = 1'b0;
    RF_RdAddr = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      req1[b] = v_eff & Src1_Read_RAU_OC & (Src1_Phy_Bank_ID == 2'(b));
      req2[b] = v_eff & Src2_Read_RAU_OC & (Src2_Phy_Bank_ID == 2'(b));
      // Occupancy is checked before this cycle's pop, so a pop never relieves a stall.
      if (({1'b0, count[b]} + (CW+1)'(req1[b]) + (CW+1)'(req2[b])) > (CW+1)'(DEPTH))
        stall = 1'b1;
      pop_en[b] = (count[b] != '0) & ~RF_WR[b];
      RF_RdAddr[b*RADDR_W +: RADDR_W] = mem[b][rptr[b]][RADDR_W-1:0];
    end
  end

  assign push1        = stall ? 4'b0000 : req1;
  assign push2        = stall ? 4'b0000 : req2;
  assign Stall_OC_RAU = stall;
  assign RF_RD        = pop_en;

  // Src1 lands at the write pointer; src2 follows it when both target one bank.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (push1[b])
        mem[b][wptr[b]] <= e1;
      if (push2[b])
        mem[b][push1[b] ? wptr[b] + PW'(1) : wptr[b]] <= e2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        wptr[b]   <= '0;
        rptr[b]   <= '0;
        count[b]  <= '0;
        ocid_r[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        wptr[b]   <= wptr[b] + PW'(push1[b]) + PW'(push2[b]);
        rptr[b]   <= rptr[b] + PW'(pop_en[b]);
        count[b]  <= count[b] + CW'(push1[b]) + CW'(push2[b]) - CW'(pop_en[b]);
        ocid_r[b] <= pop_en[b] ? {1'b1, mem[b][rptr[b]][EW-1 -: 3]} : 4'b0000;
      end
    end
  end

  assign ocid_0 = ocid_r[0];
  assign ocid_1 = ocid_r[1];
  assign ocid_2 = ocid_r[2];
  assign ocid_3 = ocid_r[3];

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Directed bench for oc_bank_arbiter: dual-bank issue, same-bank ordering,
// writeback priority, stall, pointer wrap and reset flush.
module tb_oc_bank_arbiter;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, s1_rd, s2_rd;
  logic [2:0]    s1_tag, s2_tag;
  logic [1:0]    s1_bank, s2_bank;
  logic [RW-1:0] s1_addr, s2_addr;
  logic [3:0]    rf_wr;
  logic          stall;
  logic [3:0]    rf_rd;
  logic [4*RW-1:0] rd_addr;
  logic [3:0]    ocid_0, ocid_1, ocid_2, ocid_3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oc_bank_arbiter #(.DEPTH(4), .RADDR_W(RW)) dut (
    .clk(clk), .rst(rst),
    .Valid_RAU_OC(valid),
    .Src1_Read_RAU_OC(s1_rd), .Src2_Read_RAU_OC(s2_rd),
    .Src1_OCID_RAU_OC(s1_tag), .Src2_OCID_RAU_OC(s2_tag),
    .Src1_Phy_Bank_ID(s1_bank), .Src2_Phy_Bank_ID(s2_bank),
    .Src1_Addr_RAU_OC(s1_addr), .Src2_Addr_RAU_OC(s2_addr),
    .RF_WR(rf_wr),
    .Stall_OC_RAU(stall), .RF_RD(rf_rd), .RF_RdAddr(rd_addr),
    .ocid_0(ocid_0), .ocid_1(ocid_1), .ocid_2(ocid_2), .ocid_3(ocid_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; s1_rd = 1'b0; s2_rd = 1'b0;
    s1_tag = '0; s2_tag = '0; s1_bank = '0; s2_bank = '0;
    s1_addr = '0; s2_addr = '0;
  endtask

  task automatic req(input logic r1, input logic [1:0] b1, input logic [RW-1:0] a1, input logic [2:0] t1,
                     input logic r2, input logic [1:0] b2, input logic [RW-1:0] a2, input logic [2:0] t2);
    valid = 1'b1;
    s1_rd = r1; s1_bank = b1; s1_addr = a1; s1_tag = t1;
    s2_rd = r2; s2_bank = b2; s2_addr = a2; s2_tag = t2;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_wr = '0; idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    tests++;
    if (rf_rd !== 4'b0000) begin fails++; $display("FAIL reset_rf_rd got=%b exp=0000", rf_rd); end
    tests++;
    if ({ocid_3, ocid_2, ocid_1, ocid_0} !== 16'h0000) begin
      fails++; $display("FAIL reset_ocid got=%h exp=0000", {ocid_3, ocid_2, ocid_1, ocid_0});
    end
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_two_banks();
    tick();
    req(1'b1, 2'd2, 5'd5, 3'b010, 1'b1, 2'd0, 5'd7, 3'b011);
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL two_banks_stall got=%b exp=0", stall); end
    tick(); idle(); #1;
    tests++;
    if (rf_rd !== 4'b0101) begin fails++; $display("FAIL two_banks_rd got=%b exp=0101", rf_rd); end
    tests++;
    if (rd_addr[0*RW +: RW] !== 5'd7 || rd_addr[2*RW +: RW] !== 5'd5) begin
      fails++; $display("FAIL two_banks_addr got b0=%0d b2=%0d exp b0=7 b2=5", rd_addr[0*RW +: RW], rd_addr[2*RW +: RW]);
    end
    tick();
    tests++;
    if ({ocid_3, ocid_2, ocid_1, ocid_0} !== {4'b0000, 4'b1010, 4'b0000, 4'b1011}) begin
      fails++; $display("FAIL two_banks_ocid got=%h exp=0a0b", {ocid_3, ocid_2, ocid_1, ocid_0});
    end
    tests++;
    if (rf_rd !== 4'b0000) begin fails++; $display("FAIL two_banks_empty got=%b exp=0000", rf_rd); end
    tick();
    tests++;
    if ({ocid_3, ocid_2, ocid_1, ocid_0} !== 16'h0000) begin
      fails++; $display("FAIL two_banks_ocid_clear got=%h exp=0000", {ocid_3, ocid_2, ocid_1, ocid_0});
    end
  endtask

  task automatic test_same_bank();
    req(1'b1, 2'd1, 5'd9, 3'b100, 1'b1, 2'd1, 5'd10, 3'b101);
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL same_bank_stall got=%b exp=0", stall); end
    tick(); idle(); #1;
    tests++;
    if (rf_rd !== 4'b0010 || rd_addr[1*RW +: RW] !== 5'd9) begin
      fails++; $display("FAIL same_bank_rd1 got rd=%b addr=%0d exp rd=0010 addr=9", rf_rd, rd_addr[1*RW +: RW]);
    end
    tick();
    tests++;
    if (ocid_1 !== 4'b1100) begin fails++; $display("FAIL same_bank_ocid1 got=%b exp=1100", ocid_1); end
    tests++;
    if (rf_rd !== 4'b0010 || rd_addr[1*RW +: RW] !== 5'd10) begin
      fails++; $display("FAIL same_bank_rd2 got rd=%b addr=%0d exp rd=0010 addr=10", rf_rd, rd_addr[1*RW +: RW]);
    end
    tick();
    tests++;
    if (ocid_1 !== 4'b1101) begin fails++; $display("FAIL same_bank_ocid2 got=%b exp=1101", ocid_1); end
    tests++;
    if (rf_rd !== 4'b0000) begin fails++; $display("FAIL same_bank_empty got=%b exp=0000", rf_rd); end
    tick();
    tests++;
    if (ocid_1 !== 4'b0000) begin fails++; $display("FAIL same_bank_ocid_clear got=%b exp=0000", ocid_1); end
  endtask

  task automatic test_writeback_hold();
    rf_wr = 4'b1000;
    req(1'b1, 2'd3, 5'd3, 3'b111, 1'b0, 2'd0, 5'd0, 3'b000);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (rf_rd[3] !== 1'b0 || ocid_3 !== 4'b0000) begin
        fails++; $display("FAIL wb_hold_cycle%0d got rd3=%b ocid3=%b exp rd3=0 ocid3=0000", i, rf_rd[3], ocid_3);
      end
      tick();
    end
    rf_wr = 4'b0000;
    #1;
    tests++;
    if (rf_rd !== 4'b1000 || rd_addr[3*RW +: RW] !== 5'd3) begin
      fails++; $display("FAIL wb_release_rd got rd=%b addr=%0d exp rd=1000 addr=3", rf_rd, rd_addr[3*RW +: RW]);
    end
    tick();
    tests++;
    if (ocid_3 !== 4'b1111) begin fails++; $display("FAIL wb_release_ocid got=%b exp=1111", ocid_3); end
  endtask

  task automatic test_stall();
    logic [RW-1:0] ea [4];
    ea[0] = 5'd0; ea[1] = 5'd1; ea[2] = 5'd2; ea[3] = 5'd6;
    rf_wr = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 2'd0, RW'(i), 3'(i), 1'b0, 2'd0, 5'd0, 3'b000);
      #1;
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL stall_fill%0d got=%b exp=0", i, stall); end
      tick();
    end
    req(1'b1, 2'd0, 5'd3, 3'd3, 1'b1, 2'd0, 5'd4, 3'd4);
    #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL stall_dual got=%b exp=1", stall); end
    tick();
    req(1'b1, 2'd0, 5'd6, 3'd6, 1'b0, 2'd0, 5'd0, 3'b000);
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL stall_single got=%b exp=0", stall); end
    tick();
    req(1'b1, 2'd0, 5'd7, 3'd7, 1'b0, 2'd0, 5'd0, 3'b000);
    #1;
    tests++;
    if (stall !== 1'b1) begin fails++; $display("FAIL stall_full got=%b exp=1", stall); end
    rf_wr = 4'b0000;
    #1;
    tests++;
    if (stall !== 1'b1 || rf_rd[0] !== 1'b1) begin
      fails++; $display("FAIL stall_pop_no_relief got stall=%b rd0=%b exp stall=1 rd0=1", stall, rf_rd[0]);
    end
    idle();
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (rf_rd[0] !== 1'b1 || rd_addr[0*RW +: RW] !== ea[k]) begin
        fails++; $display("FAIL stall_drain_rd%0d got rd0=%b addr=%0d exp rd0=1 addr=%0d", k, rf_rd[0], rd_addr[0*RW +: RW], ea[k]);
      end
      tick();
      tests++;
      if (ocid_0 !== {1'b1, ea[k][2:0]}) begin
        fails++; $display("FAIL stall_drain_ocid%0d got=%b exp=%b", k, ocid_0, {1'b1, ea[k][2:0]});
      end
    end
    tests++;
    if (rf_rd[0] !== 1'b0) begin fails++; $display("FAIL stall_drain_empty got=%b exp=0", rf_rd[0]); end
    tick();
  endtask

  task automatic test_wrap();
    logic [RW+2:0] q [$];
    logic [RW+2:0] head;
    logic [3:0]    exp_oc;
    int            issued, mc, cyc;
    logic          wr, exp_stall, exp_rd;
    issued = 0; mc = 0; exp_oc = '0; cyc = 0;
    while ((issued < 9 || q.size() != 0 || exp_oc != 4'b0000) && cyc < 60) begin
      wr = cyc[0] == 1'b0;
      rf_wr = {1'b0, wr, 2'b00};
      if (issued < 9) req(1'b1, 2'd2, RW'(issued), 3'(issued), 1'b0, 2'd0, 5'd0, 3'b000);
      else idle();
      #1;
      tests++;
      if (ocid_2 !== exp_oc) begin fails++; $display("FAIL wrap_ocid_c%0d got=%b exp=%b", cyc, ocid_2, exp_oc); end
      exp_stall = valid && (mc + 1 > 4);
      tests++;
      if (stall !== exp_stall) begin fails++; $display("FAIL wrap_stall_c%0d got=%b exp=%b", cyc, stall, exp_stall); end
      exp_rd = (mc > 0) && !wr;
      tests++;
      if (rf_rd[2] !== exp_rd) begin fails++; $display("FAIL wrap_rd_c%0d got=%b exp=%b", cyc, rf_rd[2], exp_rd); end
      exp_oc = 4'b0000;
      if (exp_rd) begin
        head = q.pop_front();
        tests++;
        if (rd_addr[2*RW +: RW] !== head[RW-1:0]) begin
          fails++; $display("FAIL wrap_addr_c%0d got=%0d exp=%0d", cyc, rd_addr[2*RW +: RW], head[RW-1:0]);
        end
        exp_oc = {1'b1, head[RW+2:RW]};
        mc--;
      end
      if (valid && !exp_stall) begin
        q.push_back({3'(issued), RW'(issued)});
        issued++;
        mc++;
      end
      tick();
      cyc++;
    end
    tests++;
    if (issued != 9 || q.size() != 0) begin
      fails++; $display("FAIL wrap_timeout got issued=%0d pending=%0d exp issued=9 pending=0", issued, q.size());
    end
    idle(); rf_wr = '0;
  endtask

  task automatic test_reset_mid();
    rf_wr = 4'b1111;
    req(1'b1, 2'd1, 5'd1, 3'b001, 1'b1, 2'd3, 5'd2, 3'b010);
    tick();
    req(1'b1, 2'd1, 5'd3, 3'b011, 1'b1, 2'd3, 5'd4, 3'b100);
    tick();
    rst = 1'b1; rf_wr = 4'b0000;
    req(1'b1, 2'd2, 5'd5, 3'b101, 1'b1, 2'd0, 5'd6, 3'b110);
    #1;
    tests++;
    if (stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
    tick();
    rst = 1'b0; idle();
    #1;
    tests++;
    if (rf_rd !== 4'b0000 || {ocid_3, ocid_2, ocid_1, ocid_0} !== 16'h0000) begin
      fails++; $display("FAIL rst_mid_flush got rd=%b ocid=%h exp rd=0000 ocid=0000", rf_rd, {ocid_3, ocid_2, ocid_1, ocid_0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (rf_rd !== 4'b0000 || {ocid_3, ocid_2, ocid_1, ocid_0} !== 16'h0000) begin
        fails++; $display("FAIL rst_mid_stale%0d got rd=%b ocid=%h exp rd=0000 ocid=0000", i, rf_rd, {ocid_3, ocid_2, ocid_1, ocid_0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_banks();
    test_same_bank();
    test_writeback_hold();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
